// File: rtl/gp_cmd_queue.sv
// gp_cmd_queue: draw-command FIFO feeding the graphics processor one command at a time.
// Commands are popped into operand registers, bottom-right is clamped to the 640x480
// screen, degenerate rectangles are discarded, and valid ones are issued over en/finish.
module gp_cmd_queue #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          push_opcode,
    input  logic [9:0]    push_tl_x,
    input  logic [8:0]    push_tl_y,
    input  logic [9:0]    push_br_x,
    input  logic [8:0]    push_br_y,
    input  logic [11:0]   push_arg,
    input  logic          flush,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count,
    output logic          overflow,
    output logic          dropped,
    output logic          busy,
    output logic          gp_en,
    output logic          gp_opcode,
    output logic [9:0]    gp_tl_x,
    output logic [8:0]    gp_tl_y,
    output logic [9:0]    gp_br_x,
    output logic [8:0]    gp_br_y,
    output logic [11:0]   gp_arg,
    input  logic          gp_finish
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_ISSUE = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    typedef struct packed {
        logic        opcode;
        logic [9:0]  tl_x;
        logic [8:0]  tl_y;
        logic [9:0]  br_x;
        logic [8:0]  br_y;
        logic [11:0] arg;
    } cmd_t;

    localparam logic [9:0]  MAX_X     = 10'd639;
    localparam logic [8:0]  MAX_Y     = 9'd479;
    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] ZERO_CNT  = {(AW+1){1'b0}};

    cmd_t          mem_r [DEPTH];
    cmd_t          push_cmd_s;
    cmd_t          head_s;
    cmd_t          op_r;
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic [AW:0]   count_next_s;
    logic          full_r;
    logic          empty_r;
    logic          overflow_r;
    logic          dropped_r;
    logic          busy_r;
    logic          gp_en_r;
    state_t        state_r;
    state_t        state_next_s;
    logic          push_ok_s;
    logic          pop_s;
    logic          drop_s;
    logic          launch_s;
    logic          done_s;
    logic [9:0]    clamp_br_x_s;
    logic [8:0]    clamp_br_y_s;

    assign push_cmd_s   = '{push_opcode, push_tl_x, push_tl_y, push_br_x, push_br_y, push_arg};
    assign head_s       = mem_r[rd_ptr_r];
    // A push during flush is discarded; a push while full is rejected even if a pop frees a slot.
    assign push_ok_s    = push & ~flush & ~full_r;
    assign clamp_br_x_s = (op_r.br_x > MAX_X) ? MAX_X : op_r.br_x;
    assign clamp_br_y_s = (op_r.br_y > MAX_Y) ? MAX_Y : op_r.br_y;

    // Issue sequencer: next state and the one-cycle pop/drop/launch/done strobes.
    always_comb begin
        state_next_s = state_r;
        pop_s        = 1'b0;
        drop_s       = 1'b0;
        launch_s     = 1'b0;
        done_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if ((count_r != ZERO_CNT) && !flush) begin
                    pop_s        = 1'b1;
                    state_next_s = ST_CHECK;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_CHECK: begin
                if ((op_r.tl_x > clamp_br_x_s) || (op_r.tl_y > clamp_br_y_s)) begin
                    drop_s       = 1'b1;
                    state_next_s = ST_IDLE;
                end else begin
                    launch_s     = 1'b1;
                    state_next_s = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (gp_finish) begin
                    done_s       = 1'b1;
                    state_next_s = ST_GAP;
                end else begin
                    state_next_s = ST_ISSUE;
                end
            end
            ST_GAP: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Next occupancy: flush empties the queue, a simultaneous push and pop cancel out.
    always_comb begin
        count_next_s = count_r;
        if (flush) begin
            count_next_s = ZERO_CNT;
        end else begin
            case ({push_ok_s, pop_s})
                2'b10:   count_next_s = count_r + (AW+1)'(1);
                2'b01:   count_next_s = count_r - (AW+1)'(1);
                default: count_next_s = count_r;
            endcase
        end
    end

    // Command storage; contents need no reset because occupancy is tracked by count.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_cmd_s;
        end
    end

    // Read/write pointers; flush snaps the read pointer onto the write pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (flush) begin
                rd_ptr_r <= wr_ptr_r;
            end else if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
        end
    end

    // Registered queue status and event pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r    <= ZERO_CNT;
            full_r     <= 1'b0;
            empty_r    <= 1'b1;
            overflow_r <= 1'b0;
            dropped_r  <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            count_r    <= count_next_s;
            full_r     <= (count_next_s == DEPTH_CNT);
            empty_r    <= (count_next_s == ZERO_CNT);
            overflow_r <= push & ~flush & full_r;
            dropped_r  <= drop_s;
            busy_r     <= (state_next_s != ST_IDLE);
        end
    end

    // Sequencer state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Operand registers: loaded on pop, bottom-right clamped in CHECK, frozen while issued.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_r <= '0;
        end else if (pop_s) begin
            op_r <= head_s;
        end else if (state_r == ST_CHECK) begin
            op_r.br_x <= clamp_br_x_s;
            op_r.br_y <= clamp_br_y_s;
        end
    end

    // Command-valid strobe toward the graphics processor.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gp_en_r <= 1'b0;
        end else if (launch_s) begin
            gp_en_r <= 1'b1;
        end else if (done_s) begin
            gp_en_r <= 1'b0;
        end
    end

    assign full      = full_r;
    assign empty     = empty_r;
    assign count     = count_r;
    assign overflow  = overflow_r;
    assign dropped   = dropped_r;
    assign busy      = busy_r;
    assign gp_en     = gp_en_r;
    assign gp_opcode = op_r.opcode;
    assign gp_tl_x   = op_r.tl_x;
    assign gp_tl_y   = op_r.tl_y;
    assign gp_br_x   = op_r.br_x;
    assign gp_br_y   = op_r.br_y;
    assign gp_arg    = op_r.arg;

endmodule

// File: tb/tb_gp_cmd_queue.sv
// tb_gp_cmd_queue: directed test-plan scenarios plus randomized traffic, every cycle
// compared against a command-level reference model of the queue and issuer.
module tb_gp_cmd_queue;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        push = 1'b0;
    logic        push_opcode = 1'b0;
    logic [9:0]  push_tl_x = 10'd0;
    logic [8:0]  push_tl_y = 9'd0;
    logic [9:0]  push_br_x = 10'd0;
    logic [8:0]  push_br_y = 9'd0;
    logic [11:0] push_arg = 12'd0;
    logic        flush = 1'b0;
    logic        gp_finish = 1'b0;
    logic        full, empty, overflow, dropped, busy, gp_en, gp_opcode;
    logic [AW:0] count;
    logic [9:0]  gp_tl_x, gp_br_x;
    logic [8:0]  gp_tl_y, gp_br_y;
    logic [11:0] gp_arg;

    gp_cmd_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst(rst), .push(push), .push_opcode(push_opcode),
        .push_tl_x(push_tl_x), .push_tl_y(push_tl_y), .push_br_x(push_br_x),
        .push_br_y(push_br_y), .push_arg(push_arg), .flush(flush),
        .full(full), .empty(empty), .count(count), .overflow(overflow),
        .dropped(dropped), .busy(busy), .gp_en(gp_en), .gp_opcode(gp_opcode),
        .gp_tl_x(gp_tl_x), .gp_tl_y(gp_tl_y), .gp_br_x(gp_br_x), .gp_br_y(gp_br_y),
        .gp_arg(gp_arg), .gp_finish(gp_finish)
    );

    always #5 clk = ~clk;

    typedef struct {
        int op; int tlx; int tly; int brx; int bry; int arg;
    } cmd_t;

    // Reference model: queued commands, the command being handled, and its stage
    // (0 waiting, 1 being checked, 2 on the bus, 3 re-arm cycle).
    cmd_t mq[$];
    cmd_t m_cur;
    int   m_stage = 0;
    bit   m_en = 0, m_ovf = 0, m_drop = 0;
    int   n_checks = 0, n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        cmd_t c;
        bit   take;
        bit   accept;
        if (rst) begin
            mq.delete();
            m_stage = 0; m_en = 0; m_ovf = 0; m_drop = 0;
            m_cur = '{0, 0, 0, 0, 0, 0};
        end else begin
            c = '{int'(push_opcode), int'(push_tl_x), int'(push_tl_y),
                  int'(push_br_x), int'(push_br_y), int'(push_arg)};
            m_ovf  = push && !flush && (mq.size() == DEPTH);
            accept = push && !flush && (mq.size() < DEPTH);
            take   = (m_stage == 0) && (mq.size() > 0) && !flush;
            m_drop = 0;
            case (m_stage)
                0: if (take) begin m_cur = mq.pop_front(); m_stage = 1; end
                1: begin
                    if (m_cur.brx > 639) m_cur.brx = 639;
                    if (m_cur.bry > 479) m_cur.bry = 479;
                    if (m_cur.tlx > m_cur.brx || m_cur.tly > m_cur.bry) begin
                        m_drop = 1; m_stage = 0;
                    end else begin
                        m_en = 1; m_stage = 2;
                    end
                end
                2: if (gp_finish) begin m_en = 0; m_stage = 3; end
                default: m_stage = 0;
            endcase
            if (flush) mq.delete();
            else if (accept) mq.push_back(c);
        end
    endtask

    task automatic compare();
        check("gp_en", gp_en, m_en);
        check("busy", busy, m_stage != 0);
        check("count", count, mq.size());
        check("full", full, mq.size() == DEPTH);
        check("empty", empty, mq.size() == 0);
        check("overflow", overflow, m_ovf);
        check("dropped", dropped, m_drop);
        if (m_en) begin
            check("gp_opcode", gp_opcode, m_cur.op);
            check("gp_tl_x", gp_tl_x, m_cur.tlx);
            check("gp_tl_y", gp_tl_y, m_cur.tly);
            check("gp_br_x", gp_br_x, m_cur.brx);
            check("gp_br_y", gp_br_y, m_cur.bry);
            check("gp_arg", gp_arg, m_cur.arg);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
    endtask

    task automatic do_push(input int op, input int tx, input int ty, input int bx, input int by, input int a);
        push = 1'b1; push_opcode = 1'(op);
        push_tl_x = 10'(tx); push_tl_y = 9'(ty);
        push_br_x = 10'(bx); push_br_y = 9'(by); push_arg = 12'(a);
        tick();
        push = 1'b0;
    endtask

    task automatic fin();
        gp_finish = 1'b1;
        tick();
        gp_finish = 1'b0;
    endtask

    task automatic wait_en(output int k);
        k = 0;
        while (gp_en !== 1'b1 && k < 40) begin tick(); k++; end
        if (gp_en !== 1'b1) check("wait_en_timeout", 32'd0, 32'd1);
    endtask

    int k, en_age, issued, cyc;

    initial begin
        // Reset state
        tick(); tick();
        rst = 1'b0;
        check("rst_empty", empty, 1); check("rst_count", count, 0);
        check("rst_gp_en", gp_en, 0); check("rst_busy", busy, 0);
        check("rst_tl_x", gp_tl_x, 0); check("rst_arg", gp_arg, 0);

        // Single command: issue two edges after the push edge with exact operands
        do_push(0, 10, 20, 100, 50, 'hF00);
        tick(); tick();
        check("t1_en", gp_en, 1); check("t1_tl_x", gp_tl_x, 10); check("t1_tl_y", gp_tl_y, 20);
        check("t1_br_x", gp_br_x, 100); check("t1_br_y", gp_br_y, 50); check("t1_arg", gp_arg, 'hF00);
        tick(); tick();
        fin();
        check("t1_en_fall", gp_en, 0); check("t1_busy_gap", busy, 1);
        tick();
        check("t1_busy_low", busy, 0); check("t1_empty", empty, 1);
        tick();

        // Fill and overflow with the responder silent
        for (int i = 0; i < 10; i++) do_push(0, 0, 0, 5, 5, i);
        check("t2_full", full, 1); check("t2_count", count, 8); check("t2_overflow", overflow, 1);
        for (int i = 0; i < 9; i++) begin
            wait_en(k);
            if (i > 0) check("t2_gap", k, 3);
            check("t2_order", gp_arg, i);
            fin();
        end
        repeat (4) tick();

        // Clamping, drop, and the command behind the drop
        do_push(1, 5, 6, 700, 500, 'h123);
        wait_en(k);
        check("t3_br_x", gp_br_x, 639); check("t3_br_y", gp_br_y, 479); check("t3_op", gp_opcode, 1);
        do_push(0, 640, 0, 700, 10, 'h0CC);
        do_push(0, 1, 2, 3, 4, 'h0AB);
        fin();
        k = 0;
        while (dropped !== 1'b1 && k < 20) begin tick(); k++; end
        check("t3_dropped", dropped, 1); check("t3_drop_no_en", gp_en, 0);
        wait_en(k);
        check("t3_after_drop_k", k, 2); check("t3_next_arg", gp_arg, 'h0AB);
        fin();
        repeat (3) tick();

        // Flush while a command is on the bus
        for (int i = 0; i < 5; i++) do_push(0, 0, 0, 9, 9, 'h200 + i);
        check("t4_count_pre", count, 4);
        flush = 1'b1; tick(); flush = 1'b0;
        check("t4_count", count, 0); check("t4_en_held", gp_en, 1);
        repeat (3) tick();
        check("t4_en_still", gp_en, 1); check("t4_arg", gp_arg, 'h200);
        fin();
        repeat (8) tick();
        check("t4_no_more_en", gp_en, 0); check("t4_idle", busy, 0);

        // Asynchronous reset mid-issue
        for (int i = 0; i < 4; i++) do_push(0, 0, 0, 9, 9, 'h300 + i);
        wait_en(k);
        #2 rst = 1'b1;
        #1;
        check("t5_en_async", gp_en, 0); check("t5_empty_async", empty, 1); check("t5_count_async", count, 0);
        tick();
        rst = 1'b0;
        do_push(0, 1, 1, 2, 2, 'h555);
        tick(); tick();
        check("t5_reissue_en", gp_en, 1); check("t5_reissue_arg", gp_arg, 'h555);
        fin();
        repeat (3) tick();

        // Pointer wrap: 20 streamed commands, finish two cycles after each gp_en rise
        issued = 0; en_age = 0; cyc = 0;
        for (int i = 0; i < 20 || issued < 20;) begin
            if (i < 20 && mq.size() < DEPTH) begin
                int tx, ty;
                tx = $urandom_range(0, 600); ty = $urandom_range(0, 400);
                push = 1'b1; push_opcode = 1'($urandom_range(0, 1));
                push_tl_x = 10'(tx); push_tl_y = 9'(ty);
                push_br_x = 10'(tx + $urandom_range(0, 39)); push_br_y = 9'(ty + $urandom_range(0, 79));
                push_arg = 12'('h400 + i);
                i++;
            end else begin
                push = 1'b0;
            end
            gp_finish = m_en && (en_age == 2);
            tick();
            if (m_en) en_age++; else en_age = 0;
            if (en_age == 1) begin
                check("t6_order", gp_arg, 'h400 + issued);
                issued++;
            end
            cyc++;
            if (cyc > 2000) begin
                check("t6_timeout", 32'd0, 32'd1);
                break;
            end
        end
        push = 1'b0; gp_finish = 1'b0;
        check("t6_issued", issued, 20);
        repeat (6) tick();

        // Randomized traffic: mixed valid/degenerate commands, flushes, stray finishes
        for (int c = 0; c < 600; c++) begin
            push = 1'($urandom_range(0, 1));
            push_opcode = 1'($urandom_range(0, 1));
            push_arg = 12'($urandom);
            if ($urandom_range(0, 2) == 0) begin
                push_tl_x = 10'($urandom); push_tl_y = 9'($urandom);
                push_br_x = 10'($urandom); push_br_y = 9'($urandom);
            end else begin
                int tx, ty;
                tx = $urandom_range(0, 639); ty = $urandom_range(0, 479);
                push_tl_x = 10'(tx); push_tl_y = 9'(ty);
                push_br_x = 10'(tx + $urandom_range(0, 300)); push_br_y = 9'(ty + $urandom_range(0, 30));
            end
            flush = ($urandom_range(0, 39) == 0);
            gp_finish = m_en ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
            tick();
        end
        push = 1'b0; flush = 1'b0; gp_finish = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
